// File: rtl/axi_id_remap_table_pkg.sv
// Shared helpers for the AXI ID remap table: in-flight counter sizing.
package axi_id_remap_table_pkg;

  // Counter must represent 0..max_txns inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

endpackage

// File: rtl/axi_id_remap_table_lzc.sv
// Leading/trailing zero counter: index of the first set bit from the chosen end.
module axi_id_remap_table_lzc #(
  parameter int unsigned Width    = 4,
  parameter bit          Trailing = 1'b1,
  localparam int unsigned CntW    = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  // Scan from the far end so the nearest set bit wins; all-zero yields 0.
  always_comb begin
    cnt_o = '0;
    if (Trailing) begin
      for (int i = Width - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CntW'(i);
      end
    end else begin
      for (int i = 0; i < Width; i++) begin
        if (in_i[i]) cnt_o = CntW'(Width - 1 - i);
      end
    end
  end

  assign empty_o = ~(|in_i);

endmodule

// File: rtl/axi_id_remap_table.sv
// ID remap table: allocates narrow output IDs for wide input IDs, tracks
// in-flight counts per entry and translates response IDs back.
module axi_id_remap_table
  import axi_id_remap_table_pkg::*;
#(
  parameter int unsigned InpIdWidth    = 8,
  parameter int unsigned MaxUniqInpIds = 4,
  parameter int unsigned MaxTxnsPerId  = 7,
  localparam int unsigned IdxWidth     = $clog2(MaxUniqInpIds)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic [MaxUniqInpIds-1:0] free_o,
  output logic [IdxWidth-1:0]      free_oup_id_o,
  output logic                     full_o,
  input  logic                     push_i,
  input  logic [InpIdWidth-1:0]    push_inp_id_i,
  input  logic [IdxWidth-1:0]      push_oup_id_i,
  input  logic [InpIdWidth-1:0]    exists_inp_id_i,
  output logic                     exists_o,
  output logic [IdxWidth-1:0]      exists_oup_id_o,
  output logic                     exists_full_o,
  input  logic                     pop_i,
  input  logic [IdxWidth-1:0]      pop_oup_id_i,
  output logic [InpIdWidth-1:0]    pop_inp_id_o
);

  localparam int unsigned CntWidth = cnt_width(MaxTxnsPerId);

  logic [MaxUniqInpIds-1:0]                 free;
  logic [MaxUniqInpIds-1:0]                 match;
  logic [MaxUniqInpIds-1:0]                 push_match;
  logic [MaxUniqInpIds-1:0]                 cnt_full;
  logic [MaxUniqInpIds-1:0][InpIdWidth-1:0] inp_ids;
  logic                                     match_empty;

  for (genvar gi = 0; gi < MaxUniqInpIds; gi++) begin : g_entry
    logic [InpIdWidth-1:0] inp_id_q, inp_id_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  push_hit, pop_hit;

    assign push_hit = push_i && (push_oup_id_i == IdxWidth'(gi));
    assign pop_hit  = pop_i && (pop_oup_id_i == IdxWidth'(gi));

    // A simultaneous push and pop on one entry cancel out.
    always_comb begin
      inp_id_d = inp_id_q;
      cnt_d    = cnt_q;
      if (push_hit && !pop_hit) begin
        if (cnt_q == '0) inp_id_d = push_inp_id_i;
        cnt_d = cnt_q + 1'b1;
      end else if (pop_hit && !push_hit) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        inp_id_q <= '0;
        cnt_q    <= '0;
      end else begin
        inp_id_q <= inp_id_d;
        cnt_q    <= cnt_d;
      end
    end

    assign free[gi]       = (cnt_q == '0);
    assign match[gi]      = !free[gi] && (inp_id_q == exists_inp_id_i);
    assign push_match[gi] = !free[gi] && (inp_id_q == push_inp_id_i);
    assign cnt_full[gi]   = (cnt_q == CntWidth'(MaxTxnsPerId));
    assign inp_ids[gi]    = inp_id_q;

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (push_hit && !pop_hit) |-> !cnt_full[gi]);
    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
      pop_hit |-> !free[gi]);
  end

  // Allocating a fresh entry for an ID already in flight would break ordering.
  a_no_dup_alloc : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_i && free[push_oup_id_i]) |-> !(|push_match));

  axi_id_remap_table_lzc #(
    .Width    (MaxUniqInpIds),
    .Trailing (1'b1)
  ) i_free_lzc (
    .in_i    (free),
    .cnt_o   (free_oup_id_o),
    .empty_o (full_o)
  );

  axi_id_remap_table_lzc #(
    .Width    (MaxUniqInpIds),
    .Trailing (1'b1)
  ) i_match_lzc (
    .in_i    (match),
    .cnt_o   (exists_oup_id_o),
    .empty_o (match_empty)
  );

  assign free_o        = full_o ? '0 : (MaxUniqInpIds'(1) << free_oup_id_o);
  assign exists_o      = !match_empty;
  assign exists_full_o = exists_o && cnt_full[exists_oup_id_o];
  assign pop_inp_id_o  = inp_ids[pop_oup_id_i];

endmodule

// File: tb/tb_axi_id_remap_table.sv
// Bench for axi_id_remap_table: directed scenarios plus contract-abiding
// random traffic, checked against a per-entry (id, count) table model.
module tb_axi_id_remap_table;

  localparam int N   = 4;
  localparam int MAX = 7;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] free_o;
  logic [1:0] free_oup_id_o;
  logic       full_o;
  logic       push_i;
  logic [7:0] push_inp_id_i;
  logic [1:0] push_oup_id_i;
  logic [7:0] exists_inp_id_i;
  logic       exists_o;
  logic [1:0] exists_oup_id_o;
  logic       exists_full_o;
  logic       pop_i;
  logic [1:0] pop_oup_id_i;
  logic [7:0] pop_inp_id_o;

  int n_checks = 0;
  int n_fail   = 0;

  int m_id  [N];
  int m_cnt [N];

  axi_id_remap_table #(
    .InpIdWidth    (8),
    .MaxUniqInpIds (N),
    .MaxTxnsPerId  (MAX)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .free_o          (free_o),
    .free_oup_id_o   (free_oup_id_o),
    .full_o          (full_o),
    .push_i          (push_i),
    .push_inp_id_i   (push_inp_id_i),
    .push_oup_id_i   (push_oup_id_i),
    .exists_inp_id_i (exists_inp_id_i),
    .exists_o        (exists_o),
    .exists_oup_id_o (exists_oup_id_o),
    .exists_full_o   (exists_full_o),
    .pop_i           (pop_i),
    .pop_oup_id_i    (pop_oup_id_i),
    .pop_inp_id_o    (pop_inp_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < N; e++) begin
      m_id[e]  = 0;
      m_cnt[e] = 0;
    end
  endtask

  function automatic int model_free_idx();
    for (int e = 0; e < N; e++) if (m_cnt[e] == 0) return e;
    return -1;
  endfunction

  function automatic int model_match(input int id);
    for (int e = 0; e < N; e++) if (m_cnt[e] != 0 && m_id[e] == id) return e;
    return -1;
  endfunction

  // Compare every output against the model for the inputs currently applied.
  task automatic compare_all(input string tag);
    int f, m;
    f = model_free_idx();
    m = model_match(int'(exists_inp_id_i));
    check({tag, ".full"},        full_o, f < 0);
    check({tag, ".free"},        free_o, (f < 0) ? 0 : (1 << f));
    check({tag, ".free_id"},     free_oup_id_o, (f < 0) ? 0 : f);
    check({tag, ".exists"},      exists_o, m >= 0);
    if (m >= 0) check({tag, ".exists_id"}, exists_oup_id_o, m);
    check({tag, ".exists_full"}, exists_full_o, (m >= 0) && (m_cnt[m] == MAX));
    check({tag, ".pop_id"},      pop_inp_id_o, m_id[pop_oup_id_i]);
    $display("txn %s push=%0b/%0h->%0d pop=%0b/%0d free=%b ex=%0b/%0d", tag, push_i,
             push_inp_id_i, push_oup_id_i, pop_i, pop_oup_id_i, free_o, exists_o, exists_oup_id_o);
  endtask

  // One clock cycle: apply inputs at negedge, check, then commit at posedge.
  task automatic cycle(input string tag, input bit p, input int pid, input int poid,
                       input bit q, input int qoid);
    @(negedge clk_i);
    push_i          = p;
    push_inp_id_i   = 8'(pid);
    push_oup_id_i   = 2'(poid);
    exists_inp_id_i = 8'(pid);
    pop_i           = q;
    pop_oup_id_i    = 2'(qoid);
    #1;
    compare_all(tag);
    @(posedge clk_i);
    if (p) begin
      if (m_cnt[poid] == 0) m_id[poid] = pid;
      m_cnt[poid]++;
    end
    if (q) m_cnt[qoid]--;
  endtask

  task automatic idle(input string tag, input int qid);
    cycle(tag, 1'b0, qid, 0, 1'b0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int qid, e, f, pe;
    bit want;

    rst_ni = 1'b0;
    push_i = 0; push_inp_id_i = 0; push_oup_id_i = 0;
    exists_inp_id_i = 0; pop_i = 0; pop_oup_id_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst.free", free_o, 4'b0001);
    check("rst.full", full_o, 0);
    check("rst.exists", exists_o, 0);
    rst_ni = 1'b1;

    idle("idle", 8'h5C);

    // Single allocate / retire.
    cycle("push3A", 1, 8'h3A, 0, 0, 0);
    idle("q3A", 8'h3A);
    check("q3A.exists_const", exists_o, 1);
    check("q3A.free_id_const", free_oup_id_o, 1);
    cycle("pop0", 0, 8'h3A, 0, 1, 0);
    check("pop0.inp_const", pop_inp_id_o, 8'h3A);
    idle("after_pop0", 8'h3A);
    check("after_pop0.free_const", free_o, 4'b0001);

    // Saturate entry 0 with ID 0x11.
    for (int i = 0; i < MAX; i++) cycle("sat", 1, 8'h11, 0, 0, 0);
    idle("sat_q", 8'h11);
    check("sat.exists_full_const", exists_full_o, 1);
    check("sat.full_const", full_o, 0);
    idle("sat_other", 8'h22);
    check("sat_other.exists_full_const", exists_full_o, 0);
    check("sat_other.free_id_const", free_oup_id_o, 1);
    for (int i = 0; i < MAX; i++) cycle("drain", 0, 8'h11, 0, 1, 0);

    // Fill all entries, then free entry 2.
    for (int i = 0; i < N; i++) cycle("fill", 1, 8'h10 + i, i, 0, 0);
    idle("filled", 8'h10);
    check("filled.full_const", full_o, 1);
    check("filled.free_const", free_o, 0);
    cycle("pop2", 0, 8'h12, 0, 1, 2);
    idle("after_pop2", 8'h12);
    check("after_pop2.free_id_const", free_oup_id_o, 2);
    for (int i = 0; i < N; i++) if (i != 2) cycle("clear", 0, 0, 0, 1, i);

    // Simultaneous push/pop on the same and on different entries.
    cycle("e0", 1, 8'h40, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("e1", 1, 8'h41, 1, 0, 0);
    cycle("same", 1, 8'h41, 1, 1, 1);
    cycle("diff", 1, 8'h43, 3, 1, 1);
    idle("diff_q3", 8'h43);
    check("diff.exists_id_const", exists_oup_id_o, 3);
    for (int i = 0; i < 2; i++) cycle("d1", 0, 8'h41, 0, 1, 1);
    idle("d1_gone", 8'h41);
    check("d1_gone.exists_const", exists_o, 0);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    pop_oup_id_i = 2'd3;
    #1;
    model_reset();
    check("arst.free", free_o, 4'b0001);
    check("arst.full", full_o, 0);
    check("arst.exists", exists_o, 0);
    check("arst.pop_id", pop_inp_id_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Random traffic obeying the caller contract.
    for (int t = 0; t < 400; t++) begin
      qid  = 8'h20 + int'($urandom_range(0, 7));
      want = ($urandom_range(0, 99) < 60);
      e = model_match(qid);
      f = model_free_idx();
      if (want && e >= 0 && m_cnt[e] < MAX) want = 1;
      else if (want && e < 0 && f >= 0) e = f;
      else want = 0;
      pe = int'($urandom_range(0, N - 1));
      if (m_cnt[pe] == 0 || $urandom_range(0, 99) < 45) pe = -1;
      cycle("rnd", want, qid, want ? e : 0, pe >= 0, (pe >= 0) ? pe : int'($urandom_range(0, N - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
